// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the length clamp.
package serializer_pkg;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter: reloads to BIT_CYCLES-1 and flags terminal count at zero.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = LOAD;
        end else if (enable) begin
            count_d = (count_q == '0) ? LOAD : count_q - CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) count_q <= LOAD;
        else       count_q <= count_d;
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Loads a parallel pattern and replays it MSB-first on serial_out, BIT_CYCLES clocks per bit,
// with bit_valid marking the last cycle of each bit period.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    output logic                       ready,
    output logic                       busy,
    output logic                       serial_out,
    output logic                       bit_valid,
    output logic                       done
);
    localparam int LEN_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [LEN_W-1:0]   bits_left_q, bits_left_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               serial_q, serial_d;
    logic               done_q, done_d;
    logic               timer_clear;
    logic               bit_tc;
    logic [LEN_W-1:0]   len_clamped;

    assign len_clamped = LEN_W'(clamp_len(32'(len), 32'(WIDTH)));

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (busy_q),
        .tc     (bit_tc)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d     = data_in;
                    bits_left_d = len_clamped;
                    timer_clear = 1'b1;
                    state_d     = (len_clamped == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_tc) begin
                    shift_d     = shift_q << 1;
                    bits_left_d = bits_left_q - LEN_W'(1);
                    if (bits_left_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d == ST_SHIFT);
        done_d   = (state_d == ST_DONE);
        serial_d = (state_d == ST_SHIFT) && shift_d[WIDTH-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bits_left_q <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            serial_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            serial_q    <= serial_d;
            done_q      <= done_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign serial_out = serial_q;
    assign done       = done_q;
    assign bit_valid  = busy_q && bit_tc;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed and randomized transfers against a
// cycle-indexed reference computed from the transfer timing rules.
module tb_bit_serializer;
    localparam int W  = 8;
    localparam int BC = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] len;
    logic       ready, busy, serial_out, bit_valid, done;

    logic       start1;
    logic [7:0] data1;
    logic [3:0] len1;
    logic       ready1, busy1, serial1, bit_valid1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bit_serializer #(.WIDTH(W), .BIT_CYCLES(BC)) u_dut (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in), .len(len),
        .ready(ready), .busy(busy), .serial_out(serial_out), .bit_valid(bit_valid), .done(done)
    );

    bit_serializer #(.WIDTH(W), .BIT_CYCLES(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1), .data_in(data1), .len(len1),
        .ready(ready1), .busy(busy1), .serial_out(serial1), .bit_valid(bit_valid1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ready"},      32'(ready),      32'd1);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " serial_out"}, 32'(serial_out), 32'd0);
        check({tag, " bit_valid"},  32'(bit_valid),  32'd0);
        check({tag, " done"},       32'(done),       32'd0);
    endtask

    // Called at a negedge of an idle cycle T; start is accepted at the end of T.
    // Cycle T+c expectations: bit (c-1)/BC held for c in 1..n*BC, strobe when c%BC==0,
    // done at n*BC+1, ready again at n*BC+2.
    task automatic transfer(input logic [7:0] d, input int l, input bit perturb, input bit hold);
        int n    = (l > W) ? W : l;
        int last = n * BC;
        string t;
        data_in = d;
        len     = 4'(l);
        start   = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clock);
            if (perturb && c <= last + 1) begin
                start   = 1'($urandom);
                data_in = 8'($urandom);
                len     = 4'($urandom);
            end else begin
                start = hold;
            end
            t = $sformatf("d=%02h len=%0d T+%0d", d, l, c);
            check({t, " ready"},      32'(ready),      32'(c == last + 2));
            check({t, " busy"},       32'(busy),       32'(c <= last));
            check({t, " serial_out"}, 32'(serial_out), (c <= last) ? 32'(d[W-1-(c-1)/BC]) : 32'd0);
            check({t, " bit_valid"},  32'(bit_valid),  32'(c <= last && (c % BC) == 0));
            check({t, " done"},       32'(done),       32'(c == last + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int         k;
        logic [3:0] hist;

        reset   = 1'b1;
        start   = 1'b1;
        data_in = 8'hFF;
        len     = 4'd8;
        start1  = 1'b0;
        data1   = 8'h00;
        len1    = 4'd0;
        repeat (3) begin
            @(negedge clock);
            check_idle("in reset with start");
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check_idle("after reset");
        end

        transfer(8'b1101_0110, 8, 0, 0);
        transfer(8'b1010_0000, 3, 0, 0);
        transfer(8'b1010_0000, 0, 0, 0);
        transfer(8'b1011_0011, 15, 0, 0);
        transfer(8'b0110_1001, 8, 1, 0);
        transfer(8'b1110_0001, 6, 0, 1);
        transfer(8'b0101_1100, 5, 0, 0);
        @(negedge clock);
        check_idle("gap after held start");

        // Reset during cycle T+5 of an 8-bit transfer.
        data_in = 8'hA5;
        len     = 4'd8;
        start   = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_idle("T+6 after mid-transfer reset");
        repeat (12) begin
            @(negedge clock);
            check({"no done after reset"}, 32'(done), 32'd0);
        end

        for (int i = 0; i < 20; i++) begin
            transfer(8'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        // BIT_CYCLES=1: every SHIFT cycle strobes; a 1111 detector fires after the 4th bit only.
        pat    = 8'b1111_0000;
        data1  = pat;
        len1   = 4'd8;
        start1 = 1'b1;
        @(posedge clock);
        k    = 0;
        hist = 4'b0000;
        for (int c = 1; c <= 10 && k < 8; c++) begin
            @(negedge clock);
            start1 = 1'b0;
            data1  = 8'($urandom);
            check($sformatf("bc1 bit_valid T+%0d", c), 32'(bit_valid1), 32'd1);
            check($sformatf("bc1 serial T+%0d", c), 32'(serial1), 32'(pat[W-1-k]));
            if (bit_valid1 === 1'b1) begin
                hist = {hist[2:0], serial1};
                check($sformatf("bc1 detector after bit %0d", k), 32'(hist == 4'b1111), 32'(k == 3));
                k++;
            end
        end
        check("bc1 bits sampled", 32'(k), 32'd8);
        @(negedge clock);
        check("bc1 done", 32'(done1), 32'd1);
        check("bc1 busy at done", 32'(busy1), 32'd0);
        @(negedge clock);
        check("bc1 ready", 32'(ready1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream stimulus stage for the serial sequence detector: loads a parallel bit pattern and presents it one bit at a time on a single serial line, with a one-cycle strobe marking when each bit is stable and must be sampled. Its `serial_out` drives the detector's `w` input. Its `bit_valid` serves as the detector's step enable, so a whole pattern replays deterministically instead of being keyed by hand.

## Interface
- `WIDTH`, 8: pattern register width in bits; must be ≥ 1.
- `BIT_CYCLES`, 4: clock cycles each bit is held on `serial_out`; must be ≥ 1.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level request; accepted only on a cycle where `ready`=1.
- `data_in`  in  WIDTH  pattern; bit WIDTH-1 is sent first.
- `len`  in  $clog2(WIDTH+1)  number of bits to send, counted from the MSB down.
- `ready`  out  1  high in IDLE; a new `start` is accepted.
- `busy`  out  1  high while bits are being shifted.
- `serial_out`  out  1  current bit; 0 whenever not shifting.
- `bit_valid`  out  1  one-cycle strobe on the last cycle of each bit period.
- `done`  out  1  one-cycle pulse after the final bit.

## Operation
- Clock is `clock`. Reset is synchronous, active-high, and named `reset`.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE with `start`=1 → SHIFT. Capture `data_in` into the shift register. Latch `bits_left` = min(`len`, WIDTH). Clear the period counter.
  - If the latched length is 0, go IDLE → DONE directly and emit no bits.
  - SHIFT: the period counter runs 0..BIT_CYCLES-1.
    - At count BIT_CYCLES-1: assert `bit_valid`, shift left by one (zero fill), decrement `bits_left`.
    - If `bits_left` was 1, go to DONE; otherwise restart the count at 0.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `serial_out` = shift register MSB while in SHIFT, else 0.
- `ready` = (state==IDLE). `busy` = (state==SHIFT).
- `start` while busy or in DONE is ignored, with no queueing. `data_in` and `len` are sampled only at acceptance; later changes have no effect.
- `len` > WIDTH clamps to WIDTH.
- Reset at any time: next state IDLE, shift register cleared, counters cleared.
- Reset values: `ready`=1, `busy`=0, `serial_out`=0, `bit_valid`=0, `done`=0.
- Reset dominates `start` in the same cycle.

## Timing
- `start` accepted in cycle T → the first bit appears on `serial_out` in cycle T+1.
- Bit k (k=0..n-1) is held during cycles T+1+k·BIT_CYCLES through T+(k+1)·BIT_CYCLES.
- `bit_valid` is high in cycle T+(k+1)·BIT_CYCLES.
- `done` is high in cycle T+n·BIT_CYCLES+1. `ready` returns at T+n·BIT_CYCLES+2, so back-to-back patterns are separated by at least one idle cycle.
- Length 0: `done` at T+1, `ready` at T+2.
- `serial_out` is stable for the whole bit period and changes only on the cycle after `bit_valid`.
- BIT_CYCLES=1: `bit_valid` is high on every SHIFT cycle.

## Structure
- Shared package `serializer_pkg` holds:
  - the state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE;
  - the length-clamp helper function.
- One sub-module, `bit_timer`. It is a parameterised BIT_CYCLES down-counter with synchronous clear and a terminal-count output, which drives `bit_valid` and the shift enable.
- The shift register, the `bits_left` counter and the FSM stay in `bit_serializer`.

## Test plan
All scenarios use WIDTH=8, BIT_CYCLES=2 unless noted.
- After reset: `ready`=1 and all other outputs 0. Hold `start`=1 during reset → no transfer begins.
- `data_in`=8'b1101_0110, `len`=8, start at T → `bit_valid` at T+2, T+4, …, T+16. Sampled bits are 1,1,0,1,0,1,1,0. `done` at T+17, `ready` at T+18.
- `len`=3, `data_in`=8'b1010_0000 → bits 1,0,1, `done` at T+7. `len`=0 → no `bit_valid`, `done` at T+1. `len`=15 → clamped to 8 bits.
- Toggle `start` and `data_in` during a transfer → output stream unchanged and no second transfer. `start` held high → the next transfer begins at the cycle `ready` returns.
- Assert `reset` at T+5 of an 8-bit transfer → at T+6 `serial_out`=0, `ready`=1, no `done` pulse.
- BIT_CYCLES=1, pattern 8'b1111_0000, output fed to the sequence detector stepped by `bit_valid` → the detector asserts its output after the fourth 1 and clears after the first 0.
